wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: four producer channels, each buffered in a FIFO, arbitrated round-robin onto NR_WB_PORTS write-back ports.
// Optional macro WB_BYPASS_EN lets a result arriving at an empty channel be written back in the same cycle.
module wb_arbiter #(
    parameter int unsigned NR_WB_PORTS   = 2,
    parameter int unsigned FIFO_DEPTH    = 2,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned EX_BITS       = 2*XLEN+1
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        flush_i,
    input  logic                                        flu_valid_i,
    input  logic [TRANS_ID_BITS-1:0]                    flu_trans_id_i,
    input  logic [XLEN-1:0]                             flu_result_i,
    input  logic [EX_BITS-1:0]                          flu_exception_i,
    input  logic                                        load_valid_i,
    input  logic [TRANS_ID_BITS-1:0]                    load_trans_id_i,
    input  logic [XLEN-1:0]                             load_result_i,
    input  logic [EX_BITS-1:0]                          load_exception_i,
    input  logic                                        store_valid_i,
    input  logic [TRANS_ID_BITS-1:0]                    store_trans_id_i,
    input  logic [XLEN-1:0]                             store_result_i,
    input  logic [EX_BITS-1:0]                          store_exception_i,
    input  logic                                        fpu_valid_i,
    input  logic [TRANS_ID_BITS-1:0]                    fpu_trans_id_i,
    input  logic [XLEN-1:0]                             fpu_result_i,
    input  logic [EX_BITS-1:0]                          fpu_exception_i,
    output logic [NR_WB_PORTS-1:0]                      wb_valid_o,
    output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic [NR_WB_PORTS-1:0][XLEN-1:0]            wb_data_o,
    output logic [NR_WB_PORTS-1:0][EX_BITS-1:0]         wb_ex_o,
    output logic                                        wb_stall_o,
    output logic                                        overflow_o
);
    localparam int unsigned NCH   = 4;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = TRANS_ID_BITS + XLEN + EX_BITS;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(FIFO_DEPTH - 1);

    logic [NCH-1:0]   w_in_valid;
    logic [ENT_W-1:0] w_in_ent [NCH];

    assign w_in_valid  = {fpu_valid_i, store_valid_i, load_valid_i, flu_valid_i};
    assign w_in_ent[0] = {flu_trans_id_i, flu_result_i, flu_exception_i};
    assign w_in_ent[1] = {load_trans_id_i, load_result_i, load_exception_i};
    assign w_in_ent[2] = {store_trans_id_i, store_result_i, store_exception_i};
    assign w_in_ent[3] = {fpu_trans_id_i, fpu_result_i, fpu_exception_i};

    logic [ENT_W-1:0] r_mem    [NCH][FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr [NCH];
    logic [PTR_W-1:0] r_wr_ptr [NCH];
    logic [CNT_W-1:0] r_cnt    [NCH];
    logic [1:0]       r_rr;
    logic             r_overflow;

    logic [NCH-1:0]         w_nonempty;
    logic [NCH-1:0]         w_elig;
    logic [NCH-1:0]         w_grant;
    logic [NCH-1:0]         w_pop;
    logic [NCH-1:0]         w_push;
    logic [NCH-1:0]         w_wr;
    logic [NCH-1:0]         w_drop;
    logic [NR_WB_PORTS-1:0] w_port_vld;
    logic [1:0]             w_port_ch [NR_WB_PORTS];
    logic [1:0]             w_rr_next;
    logic                   w_any_grant;
    logic                   w_stall;

    always_comb begin
        w_stall = 1'b0;
        for (int unsigned c = 0; c < NCH; c++) begin
            w_nonempty[c] = (r_cnt[c] != '0);
            if (r_cnt[c] >= STALL_CNT) w_stall = 1'b1;
        end
`ifdef WB_BYPASS_EN
        w_elig = (rst_i || flush_i) ? '0 : (w_nonempty | w_in_valid);
`else
        w_elig = (rst_i || flush_i) ? '0 : w_nonempty;
`endif
    end

    // Each port takes the first still-unclaimed eligible channel in scan order from r_rr.
    always_comb begin
        logic [1:0]     scan_ch;
        logic [NCH-1:0] left;
        scan_ch     = '0;
        left        = w_elig;
        w_grant     = '0;
        w_port_vld  = '0;
        w_rr_next   = r_rr;
        w_any_grant = 1'b0;
        for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
            w_port_ch[p] = '0;
            for (int unsigned k = 0; k < NCH; k++) begin
                scan_ch = r_rr + 2'(k);
                if (!w_port_vld[p] && left[scan_ch]) begin
                    w_port_vld[p] = 1'b1;
                    w_port_ch[p]  = scan_ch;
                end
            end
            if (w_port_vld[p]) begin
                left[w_port_ch[p]]    = 1'b0;
                w_grant[w_port_ch[p]] = 1'b1;
                w_rr_next             = w_port_ch[p] + 2'd1;
                w_any_grant           = 1'b1;
            end
        end
    end

    // A grant on an empty channel is a bypass: nothing is popped and the input is not stored.
    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            w_pop[c]  = w_grant[c] && w_nonempty[c];
            w_push[c] = w_in_valid[c] && !flush_i && !(w_grant[c] && !w_nonempty[c]);
            w_wr[c]   = w_push[c] && ((r_cnt[c] != FULL_CNT) || w_pop[c]);
            w_drop[c] = w_push[c] && !w_wr[c];
        end
    end

    always_comb begin
        logic [ENT_W-1:0] ent;
        for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
            ent = '0;
            if (w_port_vld[p]) begin
                ent = w_nonempty[w_port_ch[p]] ? r_mem[w_port_ch[p]][r_rd_ptr[w_port_ch[p]]]
                                               : w_in_ent[w_port_ch[p]];
            end
            {wb_trans_id_o[p], wb_data_o[p], wb_ex_o[p]} = ent;
        end
    end

    assign wb_valid_o = w_port_vld;
    assign wb_stall_o = w_stall;
    assign overflow_o = r_overflow;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                r_cnt[c]    <= '0;
                r_rd_ptr[c] <= '0;
                r_wr_ptr[c] <= '0;
            end
            r_rr       <= '0;
            r_overflow <= 1'b0;
        end else if (flush_i) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                r_cnt[c]    <= '0;
                r_rd_ptr[c] <= '0;
                r_wr_ptr[c] <= '0;
            end
            r_rr <= '0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (w_pop[c]) r_rd_ptr[c] <= r_rd_ptr[c] + PTR_W'(1);
                if (w_wr[c])  r_wr_ptr[c] <= r_wr_ptr[c] + PTR_W'(1);
                if (w_wr[c] && !w_pop[c])      r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                else if (!w_wr[c] && w_pop[c]) r_cnt[c] <= r_cnt[c] - CNT_W'(1);
            end
            if (|w_drop)     r_overflow <= 1'b1;
            if (w_any_grant) r_rr       <= w_rr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned c = 0; c < NCH; c++) begin
            if (w_wr[c]) r_mem[c][r_wr_ptr[c]] <= w_in_ent[c];
        end
    end
endmodule
